flash_bus_arbiter: RTL and testbench
====================================

Name: flash_bus_arbiter

Overview:
Shares the single Q-SPI flash device between two masters: the byte-wide SPI master (flash_spi, single-bit MOSI/MISO) and the quad-SPI controller (qspi, 4-bit data with per-bit OE). It replaces the ad-hoc combinational chip-select mux at the top level with a request/grant arbiter. The arbiter guarantees one owner per CS-low window, round-robin fairness and a minimum CS-high gap between owners. It produces pad-level drive/enable signals; the tristate buffers stay in the top level.

Parameters:
CS_IDLE_CYC, 4, CS-high cycles enforced after every release (flash tSHSL); legal range 1..15
MAX_HOLD_CYC, 0, owner hold-time watchdog limit in cycles; 0 disables the watchdog
HOLD_CNT_W, 16, width of the hold counter; MAX_HOLD_CYC must fit in it

Ports:
iCLK  in  1  system clock (flash clock domain)
iRESETn  in  1  asynchronous active-low reset
iSPI_REQ  in  1  SPI master requests the bus; held for the whole transaction
oSPI_GNT  out  1  SPI master owns the bus
iSPI_SCK  in  1  SPI serial clock
iSPI_MOSI  in  1  SPI data out
oSPI_MISO  out  1  flash IO1, routed to the SPI master
iQSPI_REQ  in  1  QSPI controller requests the bus
oQSPI_GNT  out  1  QSPI controller owns the bus
iQSPI_DCLK  in  1  QSPI clock
iQSPI_OEn  in  1  QSPI global output enable, active low
iQSPI_DATAOUT  in  4  QSPI data out
iQSPI_DATAOE  in  4  QSPI per-bit output enable
oQSPI_DATAIN  out  4  flash IO[3:0], routed to the QSPI controller
oFLASH_SCK  out  1  flash clock pad
oFLASH_CSn  out  1  flash chip select pad, registered
oFLASH_DO  out  4  pad drive values for IO[3:0] (IO0=MOSI, IO1=MISO, IO2=WPn, IO3=HOLDn)
oFLASH_OE  out  4  pad output enables
iFLASH_DI  in  4  pad input values
oOWNER  out  2  00 none, 01 SPI, 10 QSPI
oERR_TIMEOUT  out  1  sticky watchdog flag
iERR_CLR  in  1  clears oERR_TIMEOUT

Behaviour:
- Reset values: oFLASH_CSn=1, oSPI_GNT=0, oQSPI_GNT=0, oOWNER=00, oERR_TIMEOUT=0, oFLASH_SCK=0, oFLASH_OE=0000, oFLASH_DO=0000, internal last-owner=QSPI (so SPI wins the first tie), FSM=IDLE.
- FSM states: IDLE, OWN_SPI, OWN_QSPI, GAP.
- IDLE: requests are sampled each cycle.
  - Only one request -> that owner.
  - Both requests -> the master that is not last-owner.
  - On grant: GNT, oOWNER and CSn=0 are all asserted on the next edge. Latency is 1 cycle from the REQ-high sample.
- OWN_x: stays in the state while REQ_x=1; the other request is ignored (no preemption).
  - REQ_x=0 sampled -> GAP: GNT=0, CSn=1, oOWNER=00 on the next edge; last-owner=x; gap counter loaded with CS_IDLE_CYC-1.
- GAP: counts down to 0, then goes to IDLE.
  - CSn stays high for exactly CS_IDLE_CYC cycles before any new grant can assert it.
  - Requests arriving during GAP are held off and arbitrated in IDLE.
- Pad mux (combinational from the registered owner state):
  - SPI owner: SCK=iSPI_SCK, DO=1,1,0,MOSI (HOLDn/WPn driven high), OE=1101.
  - QSPI owner: SCK=iQSPI_DCLK, DO=iQSPI_DATAOUT, OE=iQSPI_DATAOE when iQSPI_OEn=0, else OE=0000 and SCK=0.
  - IDLE/GAP: SCK=0, OE=0000.
- Input routing: oSPI_MISO=iFLASH_DI[1] and oQSPI_DATAIN=iFLASH_DI are routed unconditionally; masters ignore them when not granted.
- Watchdog (MAX_HOLD_CYC>0):
  - The hold counter clears on grant and increments each cycle in OWN_x, saturating.
  - Reaching MAX_HOLD_CYC sets oERR_TIMEOUT. There is no forced release, because aborting a flash command mid-stream corrupts it.
  - iERR_CLR clears the flag. If set and clear coincide, set wins.
- Simultaneous events:
  - Owner drops REQ in the same cycle the other raises REQ -> the normal GAP is still enforced.
  - A requester that drops REQ before being granted is simply not granted.
- Async reset mid-transaction: CSn goes high and OE goes 0000 immediately, without waiting for the clock. After release the FSM starts in IDLE.

Test Plan:
- CS_IDLE_CYC=4; iSPI_REQ=1 at cycle 10, held to 30 -> oSPI_GNT=1 and oFLASH_CSn=0 from cycle 11; oFLASH_OE=1101 and DO[3:2]=11 throughout; CSn=1 from cycle 31; oOWNER 01 -> 00.
- Both REQs rise at cycle 5 after reset -> SPI granted at 6. SPI drops at 20 -> CSn high 21..24, QSPI granted at 25. Repeat the tie -> SPI granted (round-robin).
- QSPI owner with iQSPI_OEn=0, DATAOE=1111, DATAOUT=1010 -> oFLASH_DO=1010, oFLASH_OE=1111. With iQSPI_OEn=1 -> OE=0000 and SCK=0.
- MAX_HOLD_CYC=8; SPI holds for 20 cycles -> oERR_TIMEOUT rises 8 cycles after grant, GNT stays 1. iERR_CLR pulsed after release -> flag 0. Set and clear in the same cycle -> flag 1.
- Assert iRESETn=0 mid-QSPI transfer between clock edges -> CSn=1, OE=0000, GNT=0 immediately. Deassert with REQ still high -> regrant 1 cycle later.
- SPI requests during GAP at gap cycle 2 -> grant delayed until the gap completes; CSn-high width measured = 4 cycles.

Source files
------------

// File: rtl/flash_bus_arbiter.sv
// Request/grant arbiter sharing one Q-SPI flash between the SPI master and the QSPI controller.
// Round-robin on ties, no preemption, enforced CS-high gap and an optional hold-time watchdog.
module flash_bus_arbiter #(
    parameter int CS_IDLE_CYC  = 4,
    parameter int MAX_HOLD_CYC = 0,
    parameter int HOLD_CNT_W   = 16
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic       iSPI_REQ,
    output logic       oSPI_GNT,
    input  logic       iSPI_SCK,
    input  logic       iSPI_MOSI,
    output logic       oSPI_MISO,
    input  logic       iQSPI_REQ,
    output logic       oQSPI_GNT,
    input  logic       iQSPI_DCLK,
    input  logic       iQSPI_OEn,
    input  logic [3:0] iQSPI_DATAOUT,
    input  logic [3:0] iQSPI_DATAOE,
    output logic [3:0] oQSPI_DATAIN,
    output logic       oFLASH_SCK,
    output logic       oFLASH_CSn,
    output logic [3:0] oFLASH_DO,
    output logic [3:0] oFLASH_OE,
    input  logic [3:0] iFLASH_DI,
    output logic [1:0] oOWNER,
    output logic       oERR_TIMEOUT,
    input  logic       iERR_CLR
);

    typedef enum logic [1:0] {IDLE, OWN_SPI, OWN_QSPI, GAP} state_e;

    localparam logic [3:0]            GAP_LOAD    = 4'(CS_IDLE_CYC - 1);
    localparam bit                    WDOG_EN     = (MAX_HOLD_CYC > 0);
    localparam logic [HOLD_CNT_W-1:0] HOLD_SET_AT = HOLD_CNT_W'((MAX_HOLD_CYC > 0) ? MAX_HOLD_CYC - 1 : 0);
    localparam logic [HOLD_CNT_W-1:0] HOLD_SAT    = '1;

    state_e                state_q, state_d;
    logic                  last_qspi_q, last_qspi_d;
    logic [3:0]            gap_cnt_q, gap_cnt_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                  err_q, err_d;
    logic                  csn_q, csn_d;
    logic                  pick_spi, pick_qspi;
    logic                  arbitrate, set_err, owner_req;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q     <= IDLE;
            last_qspi_q <= 1'b1;
            gap_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            err_q       <= 1'b0;
            csn_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_qspi_q <= last_qspi_d;
            gap_cnt_q   <= gap_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            err_q       <= err_d;
            csn_q       <= csn_d;
        end
    end

    // On a tie the master that did not own the bus last wins.
    assign pick_spi  = iSPI_REQ && (!iQSPI_REQ || last_qspi_q);
    assign pick_qspi = iQSPI_REQ && !pick_spi;
    assign owner_req = (state_q == OWN_SPI) ? iSPI_REQ : iQSPI_REQ;

    always_comb begin
        state_d     = state_q;
        last_qspi_d = last_qspi_q;
        gap_cnt_d   = gap_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        err_d       = err_q;
        csn_d       = csn_q;
        arbitrate   = 1'b0;
        set_err     = 1'b0;

        case (state_q)
            IDLE: arbitrate = 1'b1;
            OWN_SPI, OWN_QSPI: begin
                if (owner_req) begin
                    if (hold_cnt_q != HOLD_SAT) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                    if (WDOG_EN && (hold_cnt_q == HOLD_SET_AT)) begin
                        set_err = 1'b1;
                    end
                end else begin
                    state_d     = GAP;
                    csn_d       = 1'b1;
                    last_qspi_d = (state_q == OWN_QSPI);
                    gap_cnt_d   = GAP_LOAD;
                end
            end
            // The last gap cycle arbitrates directly so CSn stays high exactly CS_IDLE_CYC cycles.
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    arbitrate = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arbitrate) begin
            if (pick_spi) begin
                state_d    = OWN_SPI;
                csn_d      = 1'b0;
                hold_cnt_d = '0;
            end else if (pick_qspi) begin
                state_d    = OWN_QSPI;
                csn_d      = 1'b0;
                hold_cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end

        if (set_err) begin
            err_d = 1'b1;
        end else if (iERR_CLR) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        oFLASH_SCK = 1'b0;
        oFLASH_DO  = 4'b0000;
        oFLASH_OE  = 4'b0000;
        case (state_q)
            OWN_SPI: begin
                oFLASH_SCK = iSPI_SCK;
                oFLASH_DO  = {2'b11, 1'b0, iSPI_MOSI};
                oFLASH_OE  = 4'b1101;
            end
            OWN_QSPI: begin
                oFLASH_DO = iQSPI_DATAOUT;
                if (!iQSPI_OEn) begin
                    oFLASH_SCK = iQSPI_DCLK;
                    oFLASH_OE  = iQSPI_DATAOE;
                end
            end
            default: ;
        endcase
    end

    assign oSPI_GNT     = (state_q == OWN_SPI);
    assign oQSPI_GNT    = (state_q == OWN_QSPI);
    assign oOWNER       = {state_q == OWN_QSPI, state_q == OWN_SPI};
    assign oFLASH_CSn   = csn_q;
    assign oERR_TIMEOUT = err_q;
    assign oSPI_MISO    = iFLASH_DI[1];
    assign oQSPI_DATAIN = iFLASH_DI;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Self-checking bench for flash_bus_arbiter: directed table, hand sequences for the
// multi-cycle corners, and random traffic against a cycle-level behavioural model.
module tb_flash_bus_arbiter;

    localparam int CS_IDLE  = 4;
    localparam int MAX_HOLD = 8;

    logic       iCLK = 1'b0;
    logic       iRESETn = 1'b0;
    logic       spiReq = 1'b0, spiSck = 1'b0, spiMosi = 1'b0;
    logic       qspiReq = 1'b0, qDclk = 1'b0, qOEn = 1'b1;
    logic [3:0] qDout = '0, qDoe = '0, flashDi = '0;
    logic       errClr = 1'b0;

    logic       oSPI_GNT, oSPI_MISO, oQSPI_GNT, oFLASH_SCK, oFLASH_CSn, oERR_TIMEOUT;
    logic [3:0] oQSPI_DATAIN, oFLASH_DO, oFLASH_OE;
    logic [1:0] oOWNER;

    int nVec = 0;
    int nMis = 0;

    // Behavioural model: owner 0 none / 1 SPI / 2 QSPI, cycles CSn has been high since
    // the last release, cycles the current owner has held past its grant cycle.
    int   mOwner, mLast, mHigh, mHeld;
    logic mErr;

    typedef struct {
        logic       spiReq;
        logic       qspiReq;
        logic       expSpiGnt;
        logic       expQspiGnt;
        logic       expCsn;
        logic [1:0] expOwner;
    } TableRow;

    TableRow rows[$];

    flash_bus_arbiter #(
        .CS_IDLE_CYC (CS_IDLE),
        .MAX_HOLD_CYC(MAX_HOLD),
        .HOLD_CNT_W  (16)
    ) dut (
        .iCLK         (iCLK),
        .iRESETn      (iRESETn),
        .iSPI_REQ     (spiReq),
        .oSPI_GNT     (oSPI_GNT),
        .iSPI_SCK     (spiSck),
        .iSPI_MOSI    (spiMosi),
        .oSPI_MISO    (oSPI_MISO),
        .iQSPI_REQ    (qspiReq),
        .oQSPI_GNT    (oQSPI_GNT),
        .iQSPI_DCLK   (qDclk),
        .iQSPI_OEn    (qOEn),
        .iQSPI_DATAOUT(qDout),
        .iQSPI_DATAOE (qDoe),
        .oQSPI_DATAIN (oQSPI_DATAIN),
        .oFLASH_SCK   (oFLASH_SCK),
        .oFLASH_CSn   (oFLASH_CSn),
        .oFLASH_DO    (oFLASH_DO),
        .oFLASH_OE    (oFLASH_OE),
        .iFLASH_DI    (flashDi),
        .oOWNER       (oOWNER),
        .oERR_TIMEOUT (oERR_TIMEOUT),
        .iERR_CLR     (errClr)
    );

    always #5 iCLK = ~iCLK;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] time limit");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOwner = 0;
        mLast  = 2;
        mHigh  = CS_IDLE;
        mHeld  = 0;
        mErr   = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs sampled there.
    task automatic modelStep();
        bit setNow;
        setNow = 1'b0;
        if (mOwner != 0) begin
            if ((mOwner == 1 && spiReq) || (mOwner == 2 && qspiReq)) begin
                mHeld++;
                if (mHeld == MAX_HOLD) setNow = 1'b1;
            end else begin
                mLast  = mOwner;
                mOwner = 0;
                mHigh  = 1;
            end
        end else if (mHigh >= CS_IDLE) begin
            if (spiReq && (!qspiReq || mLast == 2)) begin
                mOwner = 1;
                mHeld  = 0;
            end else if (qspiReq) begin
                mOwner = 2;
                mHeld  = 0;
            end
        end else begin
            mHigh++;
        end
        if (setNow) mErr = 1'b1;
        else if (errClr) mErr = 1'b0;
    endtask

    // Compare every DUT output with the model for the current cycle and inputs.
    task automatic checkOutput();
        logic [3:0] expOe, expDo;
        logic       expSck;
        expOe  = (mOwner == 1) ? 4'b1101 : ((mOwner == 2 && !qOEn) ? qDoe : 4'b0000);
        expSck = (mOwner == 1) ? spiSck : ((mOwner == 2 && !qOEn) ? qDclk : 1'b0);
        expDo  = (mOwner == 1) ? {3'b110, spiMosi} : ((mOwner == 2) ? qDout : 4'b0000);
        cmp("spiGnt", oSPI_GNT, mOwner == 1);
        cmp("qspiGnt", oQSPI_GNT, mOwner == 2);
        cmp("owner", oOWNER, mOwner);
        cmp("csn", oFLASH_CSn, mOwner == 0);
        cmp("sck", oFLASH_SCK, expSck);
        cmp("padDo", oFLASH_DO, expDo);
        cmp("padOe", oFLASH_OE, expOe);
        cmp("miso", oSPI_MISO, flashDi[1]);
        cmp("qspiDataIn", oQSPI_DATAIN, flashDi);
        cmp("errTimeout", oERR_TIMEOUT, mErr);
    endtask

    // Called at a falling edge: drive, check, cross the rising edge, return at next falling edge.
    task automatic applyStimulus(input logic sr, input logic qr, input logic ec);
        spiReq  = sr;
        qspiReq = qr;
        errClr  = ec;
        #1;
        checkOutput();
        @(posedge iCLK);
        modelStep();
        @(negedge iCLK);
    endtask

    task automatic doReset();
        iRESETn = 1'b0;
        spiReq  = 1'b0;
        qspiReq = 1'b0;
        errClr  = 1'b0;
        qOEn    = 1'b1;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRESETn = 1'b1;
        modelReset();
    endtask

    task automatic addRows(input int n, input logic s, input logic q, input int code);
        TableRow r;
        r.spiReq     = s;
        r.qspiReq    = q;
        r.expSpiGnt  = (code == 1);
        r.expQspiGnt = (code == 2);
        r.expCsn     = (code == 0);
        r.expOwner   = 2'(code);
        for (int i = 0; i < n; i++) rows.push_back(r);
    endtask

    initial begin
        logic sr, qr;
        int   highCnt, riseAt;

        // Directed arbitration table: code 0 = idle/gap, 1 = SPI, 2 = QSPI (state during the row).
        addRows(1, 0, 0, 0); addRows(1, 1, 1, 0); addRows(2, 1, 1, 1); addRows(1, 0, 1, 1);
        addRows(4, 0, 1, 0); addRows(1, 1, 1, 2); addRows(1, 1, 0, 2); addRows(4, 1, 0, 0);
        addRows(1, 1, 1, 1); addRows(1, 0, 1, 1); addRows(4, 1, 1, 0); addRows(1, 1, 1, 2);
        addRows(1, 0, 0, 2); addRows(1, 0, 0, 0); addRows(3, 1, 1, 0); addRows(1, 0, 0, 1);
        addRows(1, 0, 0, 0);

        // Reset values.
        doReset();
        #1;
        cmp("rstCsn", oFLASH_CSn, 1'b1);
        cmp("rstSpiGnt", oSPI_GNT, 1'b0);
        cmp("rstQspiGnt", oQSPI_GNT, 1'b0);
        cmp("rstOwner", oOWNER, 2'b00);
        cmp("rstErr", oERR_TIMEOUT, 1'b0);
        cmp("rstSck", oFLASH_SCK, 1'b0);
        cmp("rstOe", oFLASH_OE, 4'b0000);
        cmp("rstDo", oFLASH_DO, 4'b0000);
        @(negedge iCLK);

        foreach (rows[i]) begin
            cmp($sformatf("tbl%0d.spiGnt", i), oSPI_GNT, rows[i].expSpiGnt);
            cmp($sformatf("tbl%0d.qspiGnt", i), oQSPI_GNT, rows[i].expQspiGnt);
            cmp($sformatf("tbl%0d.csn", i), oFLASH_CSn, rows[i].expCsn);
            cmp($sformatf("tbl%0d.owner", i), oOWNER, rows[i].expOwner);
            applyStimulus(rows[i].spiReq, rows[i].qspiReq, 1'b0);
        end

        // QSPI pad mux with and without the global output enable.
        doReset();
        applyStimulus(0, 1, 0);
        qOEn = 1'b0; qDoe = 4'b1111; qDout = 4'b1010; qDclk = 1'b1;
        #1;
        cmp("qspiPadDo", oFLASH_DO, 4'b1010);
        cmp("qspiPadOe", oFLASH_OE, 4'b1111);
        cmp("qspiPadSck", oFLASH_SCK, 1'b1);
        qOEn = 1'b1;
        #1;
        cmp("qspiOenOe", oFLASH_OE, 4'b0000);
        cmp("qspiOenSck", oFLASH_SCK, 1'b0);
        applyStimulus(0, 0, 0);
        repeat (5) applyStimulus(0, 0, 0);

        // Watchdog: flag rises 8 cycles after grant, grant is kept, flag is sticky until cleared.
        doReset();
        applyStimulus(1, 0, 0);
        cmp("wdGrant", oSPI_GNT, 1'b1);
        cmp("spiPadOe", oFLASH_OE, 4'b1101);
        cmp("spiPadHoldWp", oFLASH_DO[3:2], 2'b11);
        riseAt = -1;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1, 0, 0);
            if (riseAt < 0 && oERR_TIMEOUT) riseAt = k;
        end
        cmp("wdRiseCycle", riseAt, 8);
        cmp("wdGntHeld", oSPI_GNT, 1'b1);
        repeat (5) applyStimulus(0, 0, 0);
        cmp("wdSticky", oERR_TIMEOUT, 1'b1);
        applyStimulus(0, 0, 1);
        cmp("wdCleared", oERR_TIMEOUT, 1'b0);
        applyStimulus(1, 0, 0);
        repeat (8) applyStimulus(1, 0, 1);
        cmp("wdSetBeatsClear", oERR_TIMEOUT, 1'b1);
        applyStimulus(1, 0, 1);
        cmp("wdClearAfterSet", oERR_TIMEOUT, 1'b0);
        applyStimulus(0, 0, 0);

        // SPI request arriving in the second gap cycle waits for the full CS-high gap.
        doReset();
        repeat (3) applyStimulus(1, 0, 0);
        highCnt = 0;
        applyStimulus(0, 0, 0);
        if (oFLASH_CSn) highCnt++;
        applyStimulus(0, 0, 0);
        if (oFLASH_CSn) highCnt++;
        for (int i = 0; i < 12 && oFLASH_CSn; i++) begin
            applyStimulus(1, 0, 0);
            if (oFLASH_CSn) highCnt++;
        end
        cmp("gapWidth", highCnt, CS_IDLE);
        cmp("gapRegrant", oSPI_GNT, 1'b1);
        applyStimulus(0, 0, 0);

        // Asynchronous reset in the middle of a QSPI transfer.
        doReset();
        qOEn = 1'b0; qDoe = 4'b1111;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        #2;
        iRESETn = 1'b0;
        #1;
        cmp("arstCsn", oFLASH_CSn, 1'b1);
        cmp("arstOe", oFLASH_OE, 4'b0000);
        cmp("arstGnt", oQSPI_GNT, 1'b0);
        cmp("arstOwner", oOWNER, 2'b00);
        @(negedge iCLK);
        iRESETn = 1'b1;
        modelReset();
        applyStimulus(0, 1, 0);
        cmp("arstRegrant", oQSPI_GNT, 1'b1);
        applyStimulus(0, 0, 0);

        // Random traffic against the model.
        doReset();
        sr = 1'b0;
        qr = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(9) == 0) sr = ~sr;
            if ($urandom_range(9) == 0) qr = ~qr;
            spiSck  = 1'($urandom_range(1));
            spiMosi = 1'($urandom_range(1));
            qDclk   = 1'($urandom_range(1));
            qOEn    = ($urandom_range(3) == 0);
            qDout   = 4'($urandom_range(15));
            qDoe    = 4'($urandom_range(15));
            flashDi = 4'($urandom_range(15));
            applyStimulus(sr, qr, $urandom_range(15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
